// File: rtl/udp2rgb_pkg.sv
// Shared definitions for the UDP pixel receiver.
//   state_t         receiver FSM states
//   HDR_*           word index of each header field within a packet
//   COORD_*, LEN_*  bit positions of the coordinate word and length field
//   MARKER_DEFAULT  low byte carried by every well-formed pixel word
package udp2rgb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACK,
      S_HEADER,
      S_COORD,
      S_DATA,
      S_DRAIN
   } state_t;

   localparam int HDR_SRC_IP = 0;
   localparam int HDR_DST_IP = 1;
   localparam int HDR_PORTS  = 2;
   localparam int HDR_LEN    = 3;

   localparam int COORD_X_LSB = 0;
   localparam int COORD_Y_LSB = 16;
   localparam int COORD_W     = 12;

   localparam int LEN_LSB = 0;
   localparam int LEN_W   = 16;
   localparam int MIN_LEN = 8;

   localparam logic [7:0] MARKER_DEFAULT = 8'hfe;

endpackage

// File: rtl/udp2rgb_pix_pos.sv
// pix_pos_gen: x/y position generator for the pixel stream.
//   clk, rst          clock, synchronous active-high reset
//   load              take coord_x/coord_y as the new position
//   advance           step x by STEP, wrapping to the next row at H_ACTIVE
//   pos_x, pos_y      current position (before this cycle's advance)
//   frame_new         loading coord_y would start a new frame (first load
//                     since reset, or y went backwards)
module pix_pos_gen #(
   parameter int STEP     = 8,
   parameter int H_ACTIVE = 1920
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [11:0] coord_x,
   input  logic [11:0] coord_y,
   input  logic        advance,
   output logic [11:0] pos_x,
   output logic [11:0] pos_y,
   output logic        frame_new
);

   localparam logic [12:0] STEP_W   = 13'(STEP);
   localparam logic [12:0] H_LIMIT  = 13'(H_ACTIVE);

   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic [11:0] prev_y_q, prev_y_d;
   logic        first_q, first_d;
   logic [12:0] x_next;

   always_comb begin
      // one extra bit: a loaded x near 4095 must not wrap below H_ACTIVE
      x_next   = {1'b0, x_q} + STEP_W;
      x_d      = x_q;
      y_d      = y_q;
      prev_y_d = prev_y_q;
      first_d  = first_q;
      if (load) begin
         x_d      = coord_x;
         y_d      = coord_y;
         prev_y_d = coord_y;
         first_d  = 1'b0;
      end else if (advance) begin
         if (x_next >= H_LIMIT) begin
            x_d = '0;
            y_d = y_q + STEP_W[11:0];
         end else begin
            x_d = x_next[11:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         prev_y_q <= '0;
         first_q  <= 1'b1;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         prev_y_q <= prev_y_d;
         first_q  <= first_d;
      end
   end

   assign pos_x     = x_q;
   assign pos_y     = y_q;
   assign frame_new = first_q || (coord_y < prev_y_q);

endmodule

// File: rtl/udp2rgb.sv
// udp2rgb: receives UDP payload words carrying subsampled pixels, checks the
// header and emits positioned pixel writes for a frame-buffer writer.
//   clk, rst                    clock, synchronous active-high reset
//   r_req, r_ack                packet pending / one-cycle acceptance
//   r_enable, r_data            received word stream
//   px_valid, px_x, px_y, px_rgb  registered pixel write
//   frame_start                 with the first pixel of a new frame
//   pkt_cnt                     good packets (wraps)
//   err_cnt                     dropped/truncated packets and bad markers
//                               (saturates)
//
// state    | meaning
// S_IDLE   | waiting for r_req; stray words ignored
// S_ACK    | r_ack high for one cycle
// S_HEADER | consuming IP/port/length words
// S_COORD  | next word is the start coordinate
// S_DATA   | one pixel per word until words_left hits 0
// S_DRAIN  | discarding the rest of a rejected or over-long packet
module udp2rgb
   import udp2rgb_pkg::*;
#(
   parameter logic [15:0] DST_PORT = 16'h4000,
   parameter int          STEP     = 8,
   parameter int          H_ACTIVE = 1920,
   parameter logic [7:0]  MARKER   = MARKER_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r_req,
   input  logic        r_enable,
   output logic        r_ack,
   input  logic [31:0] r_data,
   output logic        px_valid,
   output logic [11:0] px_x,
   output logic [11:0] px_y,
   output logic [23:0] px_rgb,
   output logic        frame_start,
   output logic [15:0] pkt_cnt,
   output logic [15:0] err_cnt
);

   state_t      state_q, state_d;
   logic [1:0]  hdr_idx_q, hdr_idx_d;
   logic        bad_q, bad_d;
   logic [13:0] words_left_q, words_left_d;
   logic        arm_q, arm_d;
   logic        px_valid_q, px_valid_d;
   logic [11:0] px_x_q, px_x_d;
   logic [11:0] px_y_q, px_y_d;
   logic [23:0] px_rgb_q, px_rgb_d;
   logic        frame_start_q, frame_start_d;
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   logic        err_inc, pkt_inc;
   logic        pos_load, pos_adv;
   logic [11:0] pos_x, pos_y;
   logic        frame_new;
   logic [15:0] len_field;
   logic        len_bad;

   assign len_field = r_data[LEN_LSB +: LEN_W];
   assign len_bad   = (len_field < 16'(MIN_LEN)) || (len_field[1:0] != 2'b00);

   pix_pos_gen #(
      .STEP     (STEP),
      .H_ACTIVE (H_ACTIVE)
   ) u_pos (
      .clk       (clk),
      .rst       (rst),
      .load      (pos_load),
      .coord_x   (r_data[COORD_X_LSB +: COORD_W]),
      .coord_y   (r_data[COORD_Y_LSB +: COORD_W]),
      .advance   (pos_adv),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .frame_new (frame_new)
   );

   always_comb begin
      state_d       = state_q;
      hdr_idx_d     = hdr_idx_q;
      bad_d         = bad_q;
      words_left_d  = words_left_q;
      arm_d         = arm_q;
      px_valid_d    = 1'b0;
      px_x_d        = px_x_q;
      px_y_d        = px_y_q;
      px_rgb_d      = px_rgb_q;
      frame_start_d = 1'b0;
      err_inc       = 1'b0;
      pkt_inc       = 1'b0;
      pos_load      = 1'b0;
      pos_adv       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (r_req) state_d = S_ACK;
         end
         S_ACK: begin
            state_d   = S_HEADER;
            hdr_idx_d = '0;
            bad_d     = 1'b0;
         end
         S_HEADER: begin
            if (r_enable) begin
               hdr_idx_d = hdr_idx_q + 2'd1;
               if (hdr_idx_q == 2'(HDR_PORTS) && r_data[15:0] != DST_PORT)
                  bad_d = 1'b1;
               if (hdr_idx_q == 2'(HDR_LEN)) begin
                  words_left_d = len_field[15:2];
                  if (bad_q || len_bad) begin
                     err_inc = 1'b1;
                     state_d = S_DRAIN;
                  end else begin
                     state_d = S_COORD;
                  end
               end
            end else if (hdr_idx_q != 2'd0) begin
               err_inc = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_COORD: begin
            if (r_enable) begin
               pos_load     = 1'b1;
               words_left_d = words_left_q - 14'd1;
               if (frame_new) arm_d = 1'b1;
               state_d = S_DATA;
            end else begin
               err_inc = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (r_enable) begin
               pos_adv = 1'b1;
               if (r_data[7:0] == MARKER) begin
                  px_valid_d    = 1'b1;
                  px_x_d        = pos_x;
                  px_y_d        = pos_y;
                  px_rgb_d      = r_data[31:8];
                  frame_start_d = arm_q;
                  arm_d         = 1'b0;
               end else begin
                  err_inc = 1'b1;
               end
               words_left_d = words_left_q - 14'd1;
               // S_DRAIN leaves on the first idle cycle, so a packet that ends
               // exactly on its length passes through it for one cycle
               if (words_left_q == 14'd1) begin
                  pkt_inc = 1'b1;
                  state_d = S_DRAIN;
               end
            end else begin
               err_inc = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (!r_enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      pkt_cnt_d = pkt_cnt_q + {15'd0, pkt_inc};
      err_cnt_d = (err_inc && err_cnt_q != 16'hffff) ? err_cnt_q + 16'd1 : err_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         hdr_idx_q     <= '0;
         bad_q         <= 1'b0;
         words_left_q  <= '0;
         arm_q         <= 1'b0;
         px_valid_q    <= 1'b0;
         px_x_q        <= '0;
         px_y_q        <= '0;
         px_rgb_q      <= '0;
         frame_start_q <= 1'b0;
         pkt_cnt_q     <= '0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         hdr_idx_q     <= hdr_idx_d;
         bad_q         <= bad_d;
         words_left_q  <= words_left_d;
         arm_q         <= arm_d;
         px_valid_q    <= px_valid_d;
         px_x_q        <= px_x_d;
         px_y_q        <= px_y_d;
         px_rgb_q      <= px_rgb_d;
         frame_start_q <= frame_start_d;
         pkt_cnt_q     <= pkt_cnt_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign r_ack       = (state_q == S_ACK);
   assign px_valid    = px_valid_q;
   assign px_x        = px_x_q;
   assign px_y        = px_y_q;
   assign px_rgb      = px_rgb_q;
   assign frame_start = frame_start_q;
   assign pkt_cnt     = pkt_cnt_q;
   assign err_cnt     = err_cnt_q;

endmodule
